rvfi_channel_sequencer: RTL

//  Serialises an NRET-wide RVFI retirement bundle into one channel at a time, lowest index first.

---
 rtl/rvfi_channel_sequencer_pkg.sv | 15 +
 rtl/rvfi_channel_sequencer_if.sv | 31 +++
 rtl/rvfi_chan_prienc.sv | 25 ++
 rtl/rvfi_channel_sequencer.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/rvfi_channel_sequencer_pkg.sv
// Shared definitions for the RVFI channel sequencer: FSM state encoding and
// the channel-index width helper.
package rvfi_channel_sequencer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } seq_state_e;

  // Channel index is at least one bit wide, even for a single channel.
  function automatic int chan_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rvfi_channel_sequencer_if.sv
// RVFI retirement bundle of NCH channels with a valid/ready handshake.
// master drives valid and data, slave returns ready.
interface rvfi_channel_sequencer_if #(
  parameter int XLEN = 32,
  parameter int NCH  = 1
);
  logic [NCH-1:0]      valid;
  logic                ready;
  logic [NCH*5-1:0]    rs1;
  logic [NCH*5-1:0]    rs2;
  logic [NCH*5-1:0]    rd;
  logic [NCH*32-1:0]   insn;
  logic [NCH*XLEN-1:0] pre_pc;
  logic [NCH*XLEN-1:0] pre_rs1;
  logic [NCH*XLEN-1:0] pre_rs2;
  logic [NCH*XLEN-1:0] post_pc;
  logic [NCH*XLEN-1:0] post_rd;
  logic [NCH-1:0]      post_trap;

  modport master (
    output valid, rs1, rs2, rd, insn, pre_pc, pre_rs1, pre_rs2,
           post_pc, post_rd, post_trap,
    input  ready
  );

  modport slave (
    input  valid, rs1, rs2, rd, insn, pre_pc, pre_rs1, pre_rs2,
           post_pc, post_rd, post_trap,
    output ready
  );
endinterface

// File: rtl/rvfi_chan_prienc.sv
// Lowest-set-bit priority encoder over the pending channel mask.
// Produces both a one-hot select and the binary channel index.
module rvfi_chan_prienc #(
  parameter int NRET = 2,
  parameter int CHW  = 1
) (
  input  logic [NRET-1:0] i_pending,
  output logic [NRET-1:0] o_onehot,
  output logic [CHW-1:0]  o_idx
);

  // Scanning downwards lets the lowest set bit win.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    for (int i = NRET - 1; i >= 0; i--) begin
      if (i_pending[i]) begin
        o_onehot    = '0;
        o_onehot[i] = 1'b1;
        o_idx       = CHW'(i);
      end
    end
  end

endmodule

// File: rtl/rvfi_channel_sequencer.sv
// Serialises an NRET-wide RVFI bundle into single retirements, lowest channel
// first, stamping each with its source channel and a running retire count.
module rvfi_channel_sequencer
  import rvfi_channel_sequencer_pkg::*;
#(
  parameter  int XLEN = 32,
  parameter  int NRET = 2,
  parameter  int CNTW = 16,
  localparam int CHW  = chan_idx_w(NRET)
) (
  input  logic                     clk,
  input  logic                     resetn,
  rvfi_channel_sequencer_if.slave  in_bus,
  rvfi_channel_sequencer_if.master out_bus,
  output logic [CHW-1:0]           out_chan,
  output logic [CNTW-1:0]          out_order,
  output logic                     busy
);

  seq_state_e           r_state;
  seq_state_e           w_next_state;
  logic [NRET-1:0]      r_pending;
  logic [NRET-1:0]      w_onehot;
  logic [CHW-1:0]       w_idx;
  logic [CNTW-1:0]      r_order;
  logic                 w_in_fire;
  logic                 w_out_fire;
  logic                 w_last;

  logic [NRET*5-1:0]    r_rs1;
  logic [NRET*5-1:0]    r_rs2;
  logic [NRET*5-1:0]    r_rd;
  logic [NRET*32-1:0]   r_insn;
  logic [NRET*XLEN-1:0] r_pre_pc;
  logic [NRET*XLEN-1:0] r_pre_rs1;
  logic [NRET*XLEN-1:0] r_pre_rs2;
  logic [NRET*XLEN-1:0] r_post_pc;
  logic [NRET*XLEN-1:0] r_post_rd;
  logic [NRET-1:0]      r_post_trap;

  rvfi_chan_prienc #(
    .NRET (NRET),
    .CHW  (CHW)
  ) u_prienc (
    .i_pending (r_pending),
    .o_onehot  (w_onehot),
    .o_idx     (w_idx)
  );

  // The selected channel is the only one left exactly when the mask equals its one-hot.
  assign w_last     = (r_pending == w_onehot);
  assign w_out_fire = out_bus.valid[0] & out_bus.ready;
  assign w_in_fire  = in_bus.ready & (|in_bus.valid);

  assign out_chan  = w_idx;
  assign out_order = r_order;
  assign busy      = |r_pending;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_in_fire) w_next_state = ST_DRAIN;
      ST_DRAIN: if (w_out_fire && w_last && !w_in_fire) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Draining the last entry reopens the input in the same cycle, so bundles flow without a bubble.
  always_comb begin
    out_bus.valid = 1'b0;
    in_bus.ready  = 1'b0;
    case (r_state)
      ST_IDLE:  in_bus.ready = 1'b1;
      ST_DRAIN: begin
        out_bus.valid = 1'b1;
        in_bus.ready  = out_bus.ready & w_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pending <= '0;
      r_order   <= '0;
    end else begin
      if (w_in_fire)       r_pending <= in_bus.valid;
      else if (w_out_fire) r_pending <= r_pending & ~w_onehot;
      if (w_out_fire)      r_order   <= r_order + CNTW'(1);
    end
  end

  // Payload holding registers carry no reset; they are only observed while out_valid is high.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_rs1       <= in_bus.rs1;
      r_rs2       <= in_bus.rs2;
      r_rd        <= in_bus.rd;
      r_insn      <= in_bus.insn;
      r_pre_pc    <= in_bus.pre_pc;
      r_pre_rs1   <= in_bus.pre_rs1;
      r_pre_rs2   <= in_bus.pre_rs2;
      r_post_pc   <= in_bus.post_pc;
      r_post_rd   <= in_bus.post_rd;
      r_post_trap <= in_bus.post_trap;
    end
  end

  always_comb begin
    out_bus.rs1       = '0;
    out_bus.rs2       = '0;
    out_bus.rd        = '0;
    out_bus.insn      = '0;
    out_bus.pre_pc    = '0;
    out_bus.pre_rs1   = '0;
    out_bus.pre_rs2   = '0;
    out_bus.post_pc   = '0;
    out_bus.post_rd   = '0;
    out_bus.post_trap = '0;
    for (int i = 0; i < NRET; i++) begin
      if (w_onehot[i]) begin
        out_bus.rs1       = r_rs1[i*5 +: 5];
        out_bus.rs2       = r_rs2[i*5 +: 5];
        out_bus.rd        = r_rd[i*5 +: 5];
        out_bus.insn      = r_insn[i*32 +: 32];
        out_bus.pre_pc    = r_pre_pc[i*XLEN +: XLEN];
        out_bus.pre_rs1   = r_pre_rs1[i*XLEN +: XLEN];
        out_bus.pre_rs2   = r_pre_rs2[i*XLEN +: XLEN];
        out_bus.post_pc   = r_post_pc[i*XLEN +: XLEN];
        out_bus.post_rd   = r_post_rd[i*XLEN +: XLEN];
        out_bus.post_trap = r_post_trap[i];
      end
    end
  end

endmodule
